// File: rtl/mem_dump_engine.sv
// mem_dump_engine: walks a range of RAM words and streams them out as
// little-endian bytes on a valid/ready port, followed by an 8-bit checksum.
module mem_dump_engine #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   word_cnt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_CSUM,
        S_FIN
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_cnt;
    logic [31:0]       r_shift;
    logic [1:0]        r_idx;
    logic [1:0]        r_lat;
    logic [7:0]        r_csum;
    logic              r_busy;
    logic              r_done;
    logic              r_re;
    logic [ADDR_W-1:0] r_maddr;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;

    logic              w_fire;
    logic [7:0]        w_sum;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W:0]   w_cnt_next;

    // Handshake and next-value helpers shared by the FSM.
    always_comb begin
        w_fire      = r_tx_valid & tx_ready_i;
        w_sum       = r_csum + r_tx_data;
        w_addr_next = r_addr + 1'b1;
        w_cnt_next  = r_cnt - 1'b1;
    end

    // Dump sequencer: request word, wait for read data, emit 4 bytes, repeat, then checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_lat      <= '0;
            r_csum     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_re       <= 1'b0;
            r_maddr    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr <= base_addr_i;
                        r_cnt  <= word_cnt_i;
                        r_csum <= '0;
                        r_busy <= 1'b1;
                        if (word_cnt_i != '0) begin
                            r_state <= S_REQ;
                            r_re    <= 1'b1;
                            r_maddr <= base_addr_i;
                        end else begin
                            r_state    <= S_CSUM;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= 8'h00;
                        end
                    end
                end
                S_REQ: begin
                    r_re    <= 1'b0;
                    r_lat   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_shift    <= mem_rdata_i;
                        r_idx      <= '0;
                        r_tx_data  <= mem_rdata_i[7:0];
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_SEND: begin
                    if (w_fire) begin
                        r_csum  <= w_sum;
                        r_shift <= {8'h00, r_shift[31:8]};
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_addr <= w_addr_next;
                            r_cnt  <= w_cnt_next;
                            if (w_cnt_next != '0) begin
                                r_state    <= S_REQ;
                                r_re       <= 1'b1;
                                r_maddr    <= w_addr_next;
                                r_tx_valid <= 1'b0;
                            end else begin
                                r_state   <= S_CSUM;
                                r_tx_data <= w_sum;
                            end
                        end else begin
                            r_tx_data <= r_shift[15:8];
                        end
                    end
                end
                S_CSUM: begin
                    if (w_fire) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        busy_o     = r_busy;
        done_o     = r_done;
        mem_re_o   = r_re;
        mem_addr_o = r_maddr;
        tx_data_o  = r_tx_data;
        tx_valid_o = r_tx_valid;
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// tb_mem_dump_engine: randomized dumps on RD_LAT=1 and RD_LAT=3 builds,
// compared against a byte-stream model computed from RAM contents.
module tb_mem_dump_engine;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready;
    logic          sel;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [31:0]   mem [4096];

    logic          busy1, done1, re1, v1;
    logic [AW-1:0] a1;
    logic [7:0]    d1;
    logic [31:0]   rd1;
    logic          busy3, done3, re3, v3;
    logic [AW-1:0] a3;
    logic [7:0]    d3;
    logic [31:0]   rd3;

    always #5 clk = ~clk;

    mem_dump_engine #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start & ~sel),
        .base_addr_i(base), .word_cnt_i(cnt),
        .busy_o(busy1), .done_o(done1),
        .mem_re_o(re1), .mem_addr_o(a1), .mem_rdata_i(rd1),
        .tx_data_o(d1), .tx_valid_o(v1), .tx_ready_i(ready)
    );

    mem_dump_engine #(.ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start_i(start & sel),
        .base_addr_i(base), .word_cnt_i(cnt),
        .busy_o(busy3), .done_o(done3),
        .mem_re_o(re3), .mem_addr_o(a3), .mem_rdata_i(rd3),
        .tx_data_o(d3), .tx_valid_o(v3), .tx_ready_i(ready)
    );

    // RAM model: data shows up RD_LAT cycles after the strobe, junk otherwise.
    logic [32:0] p1 [3];
    logic [32:0] p3 [3];
    logic [31:0] junk;
    always @(posedge clk) begin
        junk  <= $urandom;
        p1[0] <= {re1, mem[a1]};
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        p3[0] <= {re3, mem[a3]};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd1 = p1[0][32] ? p1[0][31:0] : junk;
    assign rd3 = p3[2][32] ? p3[2][31:0] : junk;

    logic          m_busy, m_done, m_re, m_valid;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    assign m_busy  = sel ? busy3 : busy1;
    assign m_done  = sel ? done3 : done1;
    assign m_re    = sel ? re3 : re1;
    assign m_valid = sel ? v3 : v1;
    assign m_addr  = sel ? a3 : a1;
    assign m_data  = sel ? d3 : d1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]    byte_q [$];
    logic [AW-1:0] addr_q [$];
    logic [7:0]    exp_b [$];
    logic [AW-1:0] exp_a [$];
    int            done_n, busy_n, pre_n, bad, stall_n, mode;
    logic          mon_en, seen_v, prev_stall;
    logic [7:0]    prev_data;

    // Observe the active DUT between clock edges.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_re) addr_q.push_back(m_addr);
            if (m_valid && ready) byte_q.push_back(m_data);
            if (m_done) begin
                done_n++;
                if (m_busy) bad++;
            end
            if (m_busy) busy_n++;
            if (m_valid) seen_v = 1'b1;
            if (m_busy && !seen_v) pre_n++;
            if (prev_stall && (!m_valid || m_data != prev_data)) bad++;
            prev_stall = m_valid && !ready;
            prev_data  = m_data;
        end
    end

    // Sink ready patterns: always, toggle with a 5-cycle stall on byte 2, random.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: ready = 1'b1;
            1: begin
                if (byte_q.size() == 2 && m_valid && stall_n < 5) begin
                    ready = 1'b0;
                    stall_n++;
                end else begin
                    ready = ~ready;
                end
            end
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic clear_mon();
        byte_q.delete();
        addr_q.delete();
        done_n     = 0;
        busy_n     = 0;
        pre_n      = 0;
        bad        = 0;
        stall_n    = 0;
        seen_v     = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic build_exp(input logic [AW-1:0] b, input logic [AW:0] c);
        logic [7:0]    sum;
        logic [AW-1:0] a;
        logic [31:0]   w;
        exp_b.delete();
        exp_a.delete();
        sum = 8'h00;
        for (int i = 0; i < int'(c); i++) begin
            a = b + AW'(i);
            exp_a.push_back(a);
            w = mem[a];
            for (int j = 0; j < 4; j++) begin
                exp_b.push_back(w[8*j +: 8]);
                sum = sum + w[8*j +: 8];
            end
        end
        exp_b.push_back(sum);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_dump(input logic s, input logic [AW-1:0] b,
                            input logic [AW:0] c, input int m,
                            input logic poke);
        int lat;
        int k;
        lat = s ? 3 : 1;
        sel = s;
        mode = m;
        base = b;
        cnt = c;
        build_exp(b, c);
        clear_mon();
        mon_en = 1'b1;
        pulse_start();
        k = 0;
        while (done_n == 0 && k < 40 * (int'(c) + 1) + 200) begin
            @(posedge clk);
            #1;
            start = poke && m_busy && ($urandom_range(0, 3) == 0);
            k++;
        end
        start = 1'b0;
        chk("done_seen", done_n > 0, 1'b1);
        repeat (4) @(posedge clk);
        #1 mon_en = 1'b0;
        chk("done_count", done_n, 1);
        chk("byte_count", byte_q.size(), exp_b.size());
        chk("addr_count", addr_q.size(), exp_a.size());
        chk("stall_or_busy_bad", bad, 0);
        for (int i = 0; i < exp_b.size() && i < byte_q.size(); i++)
            chk("byte", byte_q[i], exp_b[i]);
        for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
            chk("addr", addr_q[i], exp_a[i]);
        if (m == 0) begin
            chk("busy_cycles", busy_n, int'(c) * (5 + lat) + 1);
            if (c != 0) chk("first_latency", pre_n, 1 + lat);
        end
        if (m == 0 && m_busy) chk("busy_after", m_busy, 1'b0);
    endtask

    task automatic abort_test(input logic s);
        int k;
        sel = s;
        mode = 0;
        base = AW'($urandom);
        cnt = 4;
        clear_mon();
        mon_en = 1'b1;
        pulse_start();
        k = 0;
        while (byte_q.size() < 3 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("abort_reach", byte_q.size() >= 3, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outs",
            {m_busy, m_done, m_re, m_valid, m_data, m_addr}, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_bytes", byte_q.size(), 0);
        chk("abort_no_done", done_n, 0);
        chk("abort_no_busy", busy_n, 0);
        mon_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        sel = 1'b0;
        mode = 0;
        mon_en = 1'b0;
        base = '0;
        cnt = '0;
        clear_mon();
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[12'h010] = 32'h12345678;
        mem[12'h011] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dut1", {busy1, done1, v1, re1}, 4'b0);
        chk("reset_dut3", {busy3, done3, v3, re3}, 4'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            run_dump(s[0], 12'h010, 13'd2, 0, 1'b0);
            chk("t2_csum", byte_q.size() == 9 ? byte_q[8] : 8'hxx, 8'h4C);
            chk("t2_byte0", byte_q.size() > 0 ? byte_q[0] : 8'hxx, 8'h78);
            run_dump(s[0], 12'h010, 13'd2, 1, 1'b0);
            run_dump(s[0], 12'h123, 13'd0, 0, 1'b0);
            chk("t4_zero", byte_q.size() == 1 ? byte_q[0] : 8'hxx, 8'h00);
            run_dump(s[0], 12'hFFF, 13'd2, 2, 1'b0);
            for (int r = 0; r < 4; r++)
                run_dump(s[0], AW'($urandom), 13'($urandom_range(1, 6)),
                         2, 1'b1);
            abort_test(s[0]);
            run_dump(s[0], AW'($urandom), 13'd3, 0, 1'b1);
        end

        run_dump(1'b0, AW'($urandom), 13'd4096, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
